// File: rtl/power_pkg.sv
// Shared definitions for the power-key front end and the power engine:
// FSM encodings, power level constants and the ms-tick divider helper.
package power_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ARM     = 3'd1,
        ST_ON      = 3'd2,
        ST_OFFREQ  = 3'd3,
        ST_RELWAIT = 3'd4
    } pwr_state_t;

    localparam logic POFF = 1'b0;
    localparam logic PON  = 1'b1;

    // 11 bits of hold progress cover ARM_TIMEOUT_MS up to 2047
    localparam int HOLD_W = 11;

    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/power_key_ctrl_if.sv
// Button/engine signal bundle of the power-key controller.
interface power_key_ctrl_if;
    import power_pkg::*;

    logic              btn_raw;
    logic              power_state;
    logic              power_on;
    logic              power_off;
    logic [HOLD_W-1:0] hold_ms;
    logic              arm_fault;

    // master: the controller; slave: the board/engine side
    modport master (
        input  btn_raw, power_state,
        output power_on, power_off, hold_ms, arm_fault
    );

    modport slave (
        output btn_raw, power_state,
        input  power_on, power_off, hold_ms, arm_fault
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus ms-tick debounce; rise/fall are one-clk pulses
// issued in the same cycle the debounced level changes.
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= in;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            // any return to the accepted level restarts the count
            if (s2 == db) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_LAST) begin
                    db   <= s2;
                    cnt  <= '0;
                    rise <= s2;
                    fall <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/power_key_ctrl.sv
// Power push-button front end: long press while off requests power-up,
// short press while on issues a one-clk power-down pulse.
module power_key_ctrl
    import power_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int          DEBOUNCE_MS    = 20,
    parameter int          ARM_TIMEOUT_MS = 1200
) (
    input  logic                    clk,
    input  logic                    rst,
    power_key_ctrl_if.master        bus
);

    localparam int unsigned TICK_DIV = ms_div(CLK_HZ);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(ARM_TIMEOUT_MS);

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    logic [PW-1:0]     presc;
    logic              tick;
    logic              btn_db, btn_press, btn_release;
    pwr_state_t        state, state_n;
    logic              pon_q, poff_q, fault_q;
    logic              pon_n, poff_n, fault_n;
    logic [HOLD_W-1:0] hold_q, hold_n;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst)      presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .in   (bus.btn_raw),
        .db   (btn_db),
        .rise (btn_press),
        .fall (btn_release)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_OFF;
            pon_q   <= 1'b0;
            poff_q  <= 1'b0;
            fault_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state   <= state_n;
            pon_q   <= pon_n;
            poff_q  <= poff_n;
            fault_q <= fault_n;
            hold_q  <= hold_n;
        end
    end

    // Outputs are next-state values so they appear the cycle after the condition
    always_comb begin
        state_n = state;
        pon_n   = 1'b0;
        poff_n  = 1'b0;
        fault_n = 1'b0;
        hold_n  = '0;
        case (state)
            ST_OFF: begin
                if (bus.power_state == PON) begin
                    state_n = ST_ON;
                end else if (btn_press) begin
                    state_n = ST_ARM;
                    pon_n   = 1'b1;
                end
            end
            ST_ARM: begin
                // engine feedback wins over release and timeout
                if (bus.power_state == PON) begin
                    state_n = ST_RELWAIT;
                end else if (btn_release) begin
                    state_n = ST_OFF;
                end else if (hold_q == HOLD_MAX) begin
                    state_n = ST_RELWAIT;
                    fault_n = 1'b1;
                end else begin
                    pon_n  = 1'b1;
                    hold_n = tick ? sat_inc(hold_q) : hold_q;
                end
            end
            ST_ON: begin
                // an engine already off must not see a power_off pulse
                if (bus.power_state == POFF) begin
                    state_n = ST_OFF;
                end else if (btn_press) begin
                    state_n = ST_OFFREQ;
                    poff_n  = 1'b1;
                end
            end
            ST_OFFREQ: begin
                state_n = ST_RELWAIT;
            end
            ST_RELWAIT: begin
                if (!btn_db) state_n = (bus.power_state == PON) ? ST_ON : ST_OFF;
            end
            default: begin
                state_n = ST_OFF;
            end
        endcase
    end

    assign bus.power_on  = pon_q;
    assign bus.power_off = poff_q;
    assign bus.arm_fault = fault_q;
    assign bus.hold_ms   = hold_q;

endmodule

// File: tb/tb_power_key_ctrl.sv
// Scoreboard bench for power_key_ctrl: 10 clk per ms, 2 ms debounce, 12 ms arm timeout.
module tb_power_key_ctrl;
    import power_pkg::*;

    localparam int EV_RISE  = 1;
    localparam int EV_FALL  = 2;
    localparam int EV_POFF  = 3;
    localparam int EV_FAULT = 4;

    typedef struct {
        int kind;
        int val;
    } ev_s;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    power_key_ctrl_if bus();

    power_key_ctrl #(
        .CLK_HZ(10_000),
        .DEBOUNCE_MS(2),
        .ARM_TIMEOUT_MS(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    ev_s exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    logic prev_on = 1'b0;
    int   prev_hold = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_s e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int val);
        ev_s e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %0d, required none (t=%0t)", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
        end
    endtask

    // monitor: turns output activity into events and checks them against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.power_on && !prev_on) got(EV_RISE, 0);
                if (!bus.power_on && prev_on) got(EV_FALL, prev_hold);
                if (bus.power_off)            got(EV_POFF, prev_hold);
                if (bus.arm_fault)            got(EV_FAULT, prev_hold);
            end
            prev_on   = bus.power_on;
            prev_hold = int'(bus.hold_ms);
        end
    end

    task automatic wait_pon();
        int n = 0;
        while (bus.power_on !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_power_on", int'(bus.power_on), 1);
    endtask

    task automatic q_empty(input string name);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        bit db_moved;
        int n;
        bus.btn_raw     = 1'b1;
        bus.power_state = 1'b0;

        // reset with button held
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_power_on",  int'(bus.power_on), 0);
        chk("rst_power_off", int'(bus.power_off), 0);
        chk("rst_arm_fault", int'(bus.arm_fault), 0);
        chk("rst_hold_ms",   int'(bus.hold_ms), 0);
        chk("rst_state",     int'(dut.state), int'(ST_OFF));
        expect_ev(EV_RISE, 0);
        expect_ev(EV_FALL, 2);
        mon_en = 1'b1;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("db_after_1_tick", int'(dut.u_db.db), 0);
        repeat (8) @(negedge clk);
        chk("db_after_2_ticks", int'(dut.u_db.db), 1);
        bus.btn_raw = 1'b0;
        repeat (30) @(negedge clk);
        chk("t1_state_off", int'(dut.state), int'(ST_OFF));
        q_empty("t1_events");

        // bounce: 5 clk levels never survive two ticks
        db_moved = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) bus.btn_raw = ~bus.btn_raw;
            @(negedge clk);
            if (dut.u_db.db !== 1'b0) db_moved = 1'b1;
        end
        bus.btn_raw = 1'b0;
        repeat (30) @(negedge clk);
        chk("bounce_db_moved", int'(db_moved), 0);
        chk("bounce_power_on", int'(bus.power_on), 0);
        q_empty("t2_events");

        // abort: release 18 clk into ARM gives 4 ticks of hold
        expect_ev(EV_RISE, 0);
        expect_ev(EV_FALL, 4);
        bus.btn_raw = 1'b1;
        wait_pon();
        repeat (18) @(negedge clk);
        bus.btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_state_off", int'(dut.state), int'(ST_OFF));
        chk("abort_hold_ms", int'(bus.hold_ms), 0);
        q_empty("t4_events");

        // timeout: hold saturates at 12, one fault pulse
        expect_ev(EV_RISE, 0);
        expect_ev(EV_FALL, 12);
        expect_ev(EV_FAULT, 12);
        bus.btn_raw = 1'b1;
        wait_pon();
        repeat (150) @(negedge clk);
        chk("timeout_power_on", int'(bus.power_on), 0);
        bus.btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        chk("timeout_state_off", int'(dut.state), int'(ST_OFF));
        q_empty("t5_events");

        // power-up: engine answers 10 ticks into ARM, button kept held
        expect_ev(EV_RISE, 0);
        expect_ev(EV_FALL, 10);
        bus.btn_raw = 1'b1;
        wait_pon();
        repeat (100) @(negedge clk);
        chk("pwrup_hold_ms", int'(bus.hold_ms), 10);
        chk("pwrup_power_on_held", int'(bus.power_on), 1);
        bus.power_state = 1'b1;
        @(negedge clk);
        chk("pwrup_power_on_drop", int'(bus.power_on), 0);
        repeat (50) @(negedge clk);
        bus.btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        chk("pwrup_state_on", int'(dut.state), int'(ST_ON));
        q_empty("t3_events");

        // power-down: short press gives exactly one power_off pulse
        expect_ev(EV_POFF, 0);
        bus.btn_raw = 1'b1;
        repeat (40) @(negedge clk);
        bus.power_state = 1'b0;
        bus.btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        chk("pwrdn_state_off", int'(dut.state), int'(ST_OFF));
        q_empty("t6a_events");

        // external on, then press coincident with engine falling: no pulse
        bus.power_state = 1'b1;
        repeat (3) @(negedge clk);
        chk("ext_on_state", int'(dut.state), int'(ST_ON));
        bus.btn_raw = 1'b1;
        n = 0;
        while (dut.u_db.rise !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("coinc_press_seen", int'(dut.u_db.rise), 1);
        bus.power_state = 1'b0;
        repeat (5) @(negedge clk);
        bus.btn_raw = 1'b0;
        repeat (60) @(negedge clk);
        chk("coinc_state_off", int'(dut.state), int'(ST_OFF));
        q_empty("t6b_events");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
